// File: rtl/jenkins_oaat_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jenkins_pkg
//  Purpose  : Shared types and arithmetic for the Jenkins one-at-a-time
//             streaming hash engine. Holds the hash width, the FSM state
//             encoding, and the per-byte mix and final avalanche functions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package jenkins_pkg;

  localparam int HASH_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIN   = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Absorb one byte into the running state (all arithmetic modulo 2^32).
  function automatic logic [HASH_W-1:0] oaat_mix(input logic [HASH_W-1:0] work,
                                                  input logic [7:0]        b);
    logic [HASH_W-1:0] w;
    w = work + {24'd0, b};
    w = w + (w << 10);
    w = w ^ (w >> 6);
    return w;
  endfunction

  // Final avalanche applied once per message.
  function automatic logic [HASH_W-1:0] oaat_final(input logic [HASH_W-1:0] work);
    logic [HASH_W-1:0] f;
    f = work + (work << 3);
    f = f ^ (f >> 11);
    f = f + (f << 15);
    return f;
  endfunction

endpackage : jenkins_pkg
`default_nettype wire

// File: rtl/jenkins_oaat_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : jenkins_oaat_stream_if
//  Purpose  : Input beat stream and hash result channel of the Jenkins
//             one-at-a-time engine.
//  Signals  : in_valid/in_ready/in_data/in_last/in_nbytes  - byte stream in
//             hash_valid/hash_ready/hash/hash_len          - result out
//  Modports : master - stream producer / result consumer
//             slave  - hash engine
//  Revision : 1.0  initial release
// ============================================================================
interface jenkins_oaat_stream_if #(
  parameter int BYTES = 1,
  parameter int LEN_W = 16
);
  import jenkins_pkg::*;

  localparam int NB_W = $clog2(BYTES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*BYTES-1:0]   in_data;
  logic                 in_last;
  logic [NB_W-1:0]      in_nbytes;
  logic                 hash_valid;
  logic                 hash_ready;
  logic [HASH_W-1:0]    hash;
  logic [LEN_W-1:0]     hash_len;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, hash_ready,
    input  in_ready, hash_valid, hash, hash_len
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, hash_ready,
    output in_ready, hash_valid, hash, hash_len
  );

endinterface : jenkins_oaat_stream_if
`default_nettype wire

// File: rtl/jenkins_oaat_stream_mix_chain.sv
`default_nettype none
// ============================================================================
//  Module   : jenkins_mix_chain
//  Purpose  : Combinational chain of one-at-a-time byte mixes. Bytes are
//             absorbed from byte 0 (data_i[7:0]) upward; only the first
//             nbytes_i bytes are mixed, the rest pass the state through.
//  Ports    : work_i   - running hash state before this beat
//             data_i   - BYTES message bytes
//             nbytes_i - number of leading bytes to absorb (0..BYTES)
//             work_o   - running hash state after this beat
//  Revision : 1.0  initial release
// ============================================================================
module jenkins_mix_chain
  import jenkins_pkg::*;
#(
  parameter int BYTES = 1
) (
  input  logic [HASH_W-1:0]            work_i,
  input  logic [8*BYTES-1:0]           data_i,
  input  logic [$clog2(BYTES+1)-1:0]   nbytes_i,
  output logic [HASH_W-1:0]            work_o
);

  localparam int NB_W = $clog2(BYTES + 1);

  logic [HASH_W-1:0] w_acc;

  always_comb begin
    w_acc = work_i;
    for (int i = 0; i < BYTES; i++) begin
      if (nbytes_i > NB_W'(i)) begin
        w_acc = oaat_mix(w_acc, data_i[8*i +: 8]);
      end
    end
    work_o = w_acc;
  end

endmodule : jenkins_mix_chain
`default_nettype wire

// File: rtl/jenkins_oaat_stream.sv
`default_nettype none
// ============================================================================
//  Module   : jenkins_oaat_stream
//  Purpose  : Streaming Jenkins one-at-a-time hash. Absorbs 1..BYTES bytes
//             per accepted beat, finalises on the last beat and presents a
//             32-bit hash plus message length on a valid/ready channel.
//  Ports    : CLOCK   - clock, rising edge
//             RESET_N - synchronous active-low reset
//             bus     - jenkins_oaat_stream_if.slave (stream in, result out)
//  Revision : 1.0  initial release
// ============================================================================
module jenkins_oaat_stream
  import jenkins_pkg::*;
#(
  parameter int               BYTES = 1,
  parameter logic [HASH_W-1:0] SEED = 32'h0,
  parameter int               LEN_W = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  jenkins_oaat_stream_if.slave bus
);

  localparam int NB_W = $clog2(BYTES + 1);

  state_e              state_q, state_d;
  logic [HASH_W-1:0]   work_q, work_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic [LEN_W-1:0]    hash_len_q, hash_len_d;

  logic [NB_W-1:0]     nb_eff;
  logic [HASH_W-1:0]   work_mixed;

  // Non-last beats absorb every byte; on a last beat the count is taken
  // from in_nbytes with out-of-range values clamped to BYTES.
  always_comb begin
    nb_eff = NB_W'(BYTES);
    if (bus.in_last && (bus.in_nbytes <= NB_W'(BYTES))) begin
      nb_eff = bus.in_nbytes;
    end
  end

  jenkins_mix_chain #(
    .BYTES    (BYTES)
  ) u_mix_chain (
    .work_i   (work_q),
    .data_i   (bus.in_data),
    .nbytes_i (nb_eff),
    .work_o   (work_mixed)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      work_q     <= SEED;
      len_q      <= '0;
      hash_q     <= '0;
      hash_len_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      len_q      <= len_d;
      hash_q     <= hash_d;
      hash_len_q <= hash_len_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    len_d          = len_q;
    hash_d         = hash_q;
    hash_len_d     = hash_len_q;
    bus.in_ready   = 1'b0;
    bus.hash_valid = 1'b0;

    case (state_q)
      IDLE, ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          work_d  = work_mixed;
          len_d   = len_q + LEN_W'(nb_eff);
          state_d = bus.in_last ? FIN : ACCUM;
        end
      end
      FIN: begin
        hash_d     = oaat_final(work_q);
        hash_len_d = len_q;
        state_d    = OUT;
      end
      OUT: begin
        bus.hash_valid = 1'b1;
        if (bus.hash_ready) begin
          // Rearm for the next message; no overlap with a new input beat.
          work_d  = SEED;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.hash     = hash_q;
  assign bus.hash_len = hash_len_q;

endmodule : jenkins_oaat_stream
`default_nettype wire

// File: tb/tb_jenkins_oaat_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jenkins_oaat_stream
//  Purpose  : Directed self-checking bench for jenkins_oaat_stream. Two
//             BYTES=1 engines (LEN_W=16 and LEN_W=4) share one stimulus
//             stream; a BYTES=4 engine has its own stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jenkins_oaat_stream;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // BYTES=1 stimulus (drives both narrow engines)
  logic        v1 = 1'b0, l1 = 1'b0, hr1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic [0:0]  nb1 = '0;
  // BYTES=4 stimulus
  logic        v4 = 1'b0, l4 = 1'b0, hr4 = 1'b0;
  logic [31:0] d4 = '0;
  logic [2:0]  nb4 = '0;

  jenkins_oaat_stream_if #(.BYTES(1), .LEN_W(16)) if_a ();
  jenkins_oaat_stream_if #(.BYTES(1), .LEN_W(4))  if_w ();
  jenkins_oaat_stream_if #(.BYTES(4), .LEN_W(16)) if_4 ();

  assign if_a.in_valid = v1;  assign if_a.in_data = d1;  assign if_a.in_last = l1;
  assign if_a.in_nbytes = nb1; assign if_a.hash_ready = hr1;
  assign if_w.in_valid = v1;  assign if_w.in_data = d1;  assign if_w.in_last = l1;
  assign if_w.in_nbytes = nb1; assign if_w.hash_ready = hr1;
  assign if_4.in_valid = v4;  assign if_4.in_data = d4;  assign if_4.in_last = l4;
  assign if_4.in_nbytes = nb4; assign if_4.hash_ready = hr4;

  jenkins_oaat_stream #(.BYTES(1), .SEED(32'h0), .LEN_W(16)) u_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_a.slave));
  jenkins_oaat_stream #(.BYTES(1), .SEED(32'h0), .LEN_W(4)) u_w (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_w.slave));
  jenkins_oaat_stream #(.BYTES(4), .SEED(32'h0), .LEN_W(16)) u_4 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_4.slave));

  int checks = 0;
  int failures = 0;

  string fox = "The quick brown fox jumps over the lazy dog";
  logic [7:0] msg [0:63];

  localparam logic [31:0] H_A   = 32'hca2e9442;
  localparam logic [31:0] H_FOX = 32'h519e91f5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference one-at-a-time hash of msg[0..n-1], SEED=0.
  function automatic logic [31:0] ref_hash(input int n);
    logic [31:0] h;
    h = 32'h0;
    for (int i = 0; i < n; i++) begin
      h = h + {24'd0, msg[i]};
      h = h + (h << 10);
      h = h ^ (h >> 6);
    end
    h = h + (h << 3);
    h = h ^ (h >> 11);
    h = h + (h << 15);
    return h;
  endfunction

  task automatic send1(input logic [7:0] b, input logic last, input logic nb);
    int t;
    t = 0;
    v1 = 1'b1; d1 = b; l1 = last; nb1 = nb;
    while (!if_a.in_ready && t < 50) begin @(posedge CLOCK); #1; t++; end
    check("send1_ready", {31'd0, if_a.in_ready}, 32'd1);
    @(posedge CLOCK); #1;
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    t = 0;
    v4 = 1'b1; d4 = d; l4 = last; nb4 = nb;
    while (!if_4.in_ready && t < 50) begin @(posedge CLOCK); #1; t++; end
    check("send4_ready", {31'd0, if_4.in_ready}, 32'd1);
    @(posedge CLOCK); #1;
    v4 = 1'b0; l4 = 1'b0;
  endtask

  // Wait for both narrow engines to present a result, capture, then accept.
  task automatic get1(output logic [31:0] h, output logic [15:0] l,
                      output logic [31:0] hw, output logic [3:0] lw);
    int t;
    t = 0;
    while (!(if_a.hash_valid && if_w.hash_valid) && t < 20) begin @(posedge CLOCK); #1; t++; end
    check("get1_valid", {30'd0, if_a.hash_valid, if_w.hash_valid}, 32'd3);
    h = if_a.hash; l = if_a.hash_len; hw = if_w.hash; lw = if_w.hash_len;
    hr1 = 1'b1;
    @(posedge CLOCK); #1;
    hr1 = 1'b0;
  endtask

  task automatic get4(output logic [31:0] h, output logic [15:0] l);
    int t;
    t = 0;
    while (!if_4.hash_valid && t < 20) begin @(posedge CLOCK); #1; t++; end
    check("get4_valid", {31'd0, if_4.hash_valid}, 32'd1);
    h = if_4.hash; l = if_4.hash_len;
    hr4 = 1'b1;
    @(posedge CLOCK); #1;
    hr4 = 1'b0;
  endtask

  initial begin
    logic [31:0] h, hw, h0;
    logic [15:0] l, l0;
    logic [3:0]  lw;
    logic [7:0]  c0, c1, c2, c3;

    // ---- reset ----
    repeat (3) @(posedge CLOCK);
    #1 RESET_N = 1'b1;
    check("rst_in_ready_a", {31'd0, if_a.in_ready}, 32'd1);
    check("rst_hash_valid_a", {31'd0, if_a.hash_valid}, 32'd0);
    check("rst_hash_a", if_a.hash, 32'd0);
    check("rst_hash_len_a", {16'd0, if_a.hash_len}, 32'd0);
    check("rst_in_ready_4", {31'd0, if_4.in_ready}, 32'd1);
    check("rst_hash_valid_4", {31'd0, if_4.hash_valid}, 32'd0);

    // ---- "a", with latency: FIN after accept edge, OUT one edge later ----
    send1(8'h61, 1'b1, 1'b1);
    check("lat_a_fin", {31'd0, if_a.hash_valid}, 32'd0);
    check("lat_a_fin_ready", {31'd0, if_a.in_ready}, 32'd0);
    @(posedge CLOCK); #1;
    check("lat_a_out", {31'd0, if_a.hash_valid}, 32'd1);
    get1(h, l, hw, lw);
    check("a_hash", h, H_A);
    check("a_len", {16'd0, l}, 32'd1);
    check("a_hash_w", hw, H_A);
    check("a_in_ready_after", {31'd0, if_a.in_ready}, 32'd1);

    // ---- fox, one byte per beat with random gaps ----
    for (int i = 0; i < 43; i++) begin
      v1 = 1'b0; d1 = 8'($urandom); l1 = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge CLOCK); #1; end
      send1(fox[i], i == 42, 1'b1);
    end
    get1(h, l, hw, lw);
    check("fox1_hash", h, H_FOX);
    check("fox1_len", {16'd0, l}, 32'd43);
    check("fox1_hash_w", hw, H_FOX);
    check("fox1_len_w", {28'd0, lw}, 32'd11);

    // ---- empty message ----
    send1(8'h99, 1'b1, 1'b0);
    get1(h, l, hw, lw);
    check("empty_hash", h, 32'd0);
    check("empty_len", {16'd0, l}, 32'd0);

    // ---- hold result with hash_ready low while beats are offered ----
    send1(8'h61, 1'b1, 1'b1);
    @(posedge CLOCK); #1;
    h0 = if_a.hash; l0 = if_a.hash_len;
    v1 = 1'b1; d1 = 8'h55; l1 = 1'b1; nb1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK); #1;
      check("hold_valid", {31'd0, if_a.hash_valid}, 32'd1);
      check("hold_hash", if_a.hash, H_A);
      check("hold_len", {16'd0, if_a.hash_len}, 32'd1);
      check("hold_in_ready", {31'd0, if_a.in_ready}, 32'd0);
    end
    v1 = 1'b0; l1 = 1'b0;
    get1(h, l, hw, lw);
    check("hold_final_hash", h, H_A);
    check("hold_final_len", {16'd0, l}, 32'd1);
    check("hold_release_ready", {31'd0, if_a.in_ready}, 32'd1);
    send1(8'h61, 1'b1, 1'b1);
    get1(h, l, hw, lw);
    check("after_hold_hash", h, H_A);
    check("after_hold_len", {16'd0, l}, 32'd1);

    // ---- reset mid-message aborts it ----
    for (int i = 0; i < 10; i++) send1(fox[i], 1'b0, 1'b1);
    RESET_N = 1'b0;
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    check("abort_ready", {31'd0, if_a.in_ready}, 32'd1);
    repeat (3) begin
      @(posedge CLOCK); #1;
      check("abort_no_result", {31'd0, if_a.hash_valid}, 32'd0);
    end
    send1(8'h61, 1'b1, 1'b1);
    get1(h, l, hw, lw);
    check("abort_a_hash", h, H_A);
    check("abort_a_len", {16'd0, l}, 32'd1);

    // ---- 20 one-byte beats: length wraps at LEN_W=4 ----
    for (int i = 0; i < 20; i++) msg[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 20; i++) send1(msg[i], i == 19, 1'b1);
    get1(h, l, hw, lw);
    check("wrap_hash", h, ref_hash(20));
    check("wrap_hash_w", hw, ref_hash(20));
    check("wrap_len", {16'd0, l}, 32'd20);
    check("wrap_len_w", {28'd0, lw}, 32'd4);

    // ---- fox on BYTES=4: 10 full beats + last with 3 bytes (byte 3 junk) ----
    for (int k = 0; k < 10; k++) begin
      c0 = fox[4*k]; c1 = fox[4*k+1]; c2 = fox[4*k+2]; c3 = fox[4*k+3];
      send4({c3, c2, c1, c0}, 1'b0, 3'd4);
    end
    c0 = fox[40]; c1 = fox[41]; c2 = fox[42];
    send4({8'hAA, c2, c1, c0}, 1'b1, 3'd3);
    get4(h, l);
    check("fox4_hash", h, H_FOX);
    check("fox4_len", {16'd0, l}, 32'd43);

    // ---- illegal in_nbytes clamps to BYTES ----
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h64;
    send4(32'h64636261, 1'b1, 3'd7);
    get4(h, l);
    check("clamp_hash", h, ref_hash(4));
    check("clamp_len", {16'd0, l}, 32'd4);

    // ---- last beat with zero bytes after a full beat ----
    send4(32'h64636261, 1'b0, 3'd0);
    send4(32'hDEADBEEF, 1'b1, 3'd0);
    get4(h, l);
    check("tail0_hash", h, ref_hash(4));
    check("tail0_len", {16'd0, l}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jenkins_oaat_stream
`default_nettype wire
